// File: rtl/obi_apb_bridge.sv
// Ibex data-side req/gnt/rvalid to APB3/APB4 master bridge.
// One outstanding transfer, SETUP/ACCESS sequencing, optional ACCESS-phase timeout.
module obi_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   apb_pwdata_o,
  output logic                        apb_pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0] apb_pstrb_o,
  output logic                        apb_psel_o,
  output logic                        apb_penable_o,
  input  logic                        apb_pready_i,
  input  logic [APB_DATA_WIDTH-1:0]   apb_prdata_i,
  input  logic                        apb_pslverr_i
);

  localparam int unsigned AW    = APB_ADDR_WIDTH;
  localparam int unsigned DW    = APB_DATA_WIDTH;
  localparam int unsigned SW    = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [AW-1:0]    paddr_q,   paddr_d;
  logic [DW-1:0]    pwdata_q,  pwdata_d;
  logic             pwrite_q,  pwrite_d;
  logic [SW-1:0]    pstrb_q,   pstrb_d;
  logic             psel_q,    psel_d;
  logic             penable_q, penable_d;
  logic             rvalid_q,  rvalid_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, grant and completion logic
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    pstrb_d    = pstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    data_gnt_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          data_gnt_o = 1'b1;
          paddr_d    = data_addr_i;
          pwdata_d   = data_wdata_i;
          pwrite_d   = data_we_i;
          pstrb_d    = data_we_i ? data_be_i : {SW{1'b1}};
          cnt_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (apb_pready_i) begin
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : apb_prdata_i;
          err_d    = apb_pslverr_i;
          state_d  = IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          // Abandon a stalled slave; any later pready is seen with psel low
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pstrb_o   = pstrb_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_obi_apb_bridge.sv
// Directed bench for obi_apb_bridge: transaction-level model checked every cycle
// plus literal expectations for each scenario.
module tb_obi_apb_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          rst_n;
  logic          data_req;
  logic          data_gnt;
  logic          data_we;
  logic [SW-1:0] data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          data_err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic [SW-1:0] pstrb;
  logic          psel;
  logic          penable;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  obi_apb_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (data_req),
    .data_gnt_o   (data_gnt),
    .data_we_i    (data_we),
    .data_be_i    (data_be),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_rvalid_o(data_rvalid),
    .data_rdata_o (data_rdata),
    .data_err_o   (data_err),
    .apb_paddr_o  (paddr),
    .apb_pwdata_o (pwdata),
    .apb_pwrite_o (pwrite),
    .apb_pstrb_o  (pstrb),
    .apb_psel_o   (psel),
    .apb_penable_o(penable),
    .apb_pready_i (pready),
    .apb_prdata_i (prdata),
    .apb_pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy from grant until completion; acc counts ACCESS cycles
  bit          m_busy;
  int          m_acc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [SW-1:0] m_strb;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_acc <= 0; m_addr <= '0; m_wdata <= '0; m_we <= 1'b0;
      m_strb <= '0; m_rvalid <= 1'b0; m_rdata <= '0; m_err <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      if (!m_busy) begin
        if (data_req) begin
          m_busy <= 1'b1; m_acc <= 0; m_addr <= data_addr; m_wdata <= data_wdata;
          m_we <= data_we; m_strb <= data_we ? data_be : 4'hF;
        end
      end else if (m_acc == 0) begin
        m_acc <= 1;
      end else if (pready) begin
        m_busy <= 1'b0; m_rvalid <= 1'b1; m_err <= pslverr;
        m_rdata <= m_we ? '0 : prdata;
      end else if (m_acc == TO) begin
        m_busy <= 1'b0; m_rvalid <= 1'b1; m_err <= 1'b1; m_rdata <= '0;
      end else begin
        m_acc <= m_acc + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && !done) begin
      chk("gnt",     data_gnt,    !m_busy && data_req);
      chk("psel",    psel,        m_busy);
      chk("penable", penable,     m_busy && (m_acc >= 1));
      chk("paddr",   paddr,       m_addr);
      chk("pwdata",  pwdata,      m_wdata);
      chk("pwrite",  pwrite,      m_we);
      chk("pstrb",   pstrb,       m_strb);
      chk("rvalid",  data_rvalid, m_rvalid);
      chk("rdata",   data_rdata,  m_rdata);
      chk("err",     data_err,    m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0;
    data_wdata = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_rvalid", data_rvalid, 1'b0);
    chk("rst_rdata", data_rdata, 32'h0);
    rst_n = 1'b1;

    // Zero-wait read
    cyc(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1A10_1000;
    pready = 1'b1; prdata = 32'hDEAD_BEEF; #1;
    chk("rd0_gnt", data_gnt, 1'b1);
    cyc(); data_req = 1'b0; #1;
    chk("rd0_psel", psel, 1'b1);
    chk("rd0_setup_pen", penable, 1'b0);
    chk("rd0_paddr", paddr, 32'h1A10_1000);
    chk("rd0_pstrb", pstrb, 4'hF);
    cyc(); #1;
    chk("rd0_penable", penable, 1'b1);
    cyc(); #1;
    chk("rd0_rvalid", data_rvalid, 1'b1);
    chk("rd0_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("rd0_err", data_err, 1'b0);
    cyc(); #1;
    chk("rd0_pulse", data_rvalid, 1'b0);
    chk("rd0_hold", data_rdata, 32'hDEAD_BEEF);

    // Write with three wait states
    cyc(); pready = 1'b0; data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_wdata = 32'h1234_5678; data_addr = 32'h1A10_2004; #1;
    chk("wr_gnt", data_gnt, 1'b1);
    cyc(); data_req = 1'b0; data_wdata = 32'hFFFF_0000;
    repeat (3) cyc();
    cyc(); pready = 1'b1; #1;
    chk("wr_pwdata", pwdata, 32'h1234_5678);
    chk("wr_pstrb", pstrb, 4'b0011);
    chk("wr_pwrite", pwrite, 1'b1);
    chk("wr_penable", penable, 1'b1);
    cyc(); pready = 1'b0; #1;
    chk("wr_rvalid", data_rvalid, 1'b1);
    chk("wr_rdata", data_rdata, 32'h0);

    // Slave error on a read
    cyc(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1A10_3008;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_F00D;
    cyc(); data_req = 1'b0;
    cyc();
    cyc(); #1;
    chk("se_rvalid", data_rvalid, 1'b1);
    chk("se_err", data_err, 1'b1);
    chk("se_rdata", data_rdata, 32'hCAFE_F00D);
    pslverr = 1'b0;

    // Timeout after eight ACCESS cycles
    cyc(); data_req = 1'b1; data_addr = 32'h1A10_4000; pready = 1'b0; #1;
    chk("to_gnt", data_gnt, 1'b1);
    cyc(); data_req = 1'b0;
    repeat (8) cyc();
    #1;
    chk("to_last_pen", penable, 1'b1);
    cyc(); #1;
    chk("to_psel", psel, 1'b0);
    chk("to_rvalid", data_rvalid, 1'b1);
    chk("to_err", data_err, 1'b1);
    chk("to_rdata", data_rdata, 32'h0);
    cyc(); pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("to_late_rvalid", data_rvalid, 1'b0);
    end
    pready = 1'b0;

    // Back-to-back reads with request held high
    cyc(); data_req = 1'b1; data_addr = 32'h1A10_5000; pready = 1'b1;
    prdata = 32'h1111_2222; #1;
    chk("b2b_gnt0", data_gnt, 1'b1);
    cyc(); data_addr = 32'h1A10_6004; #1;
    chk("b2b_nognt", data_gnt, 1'b0);
    chk("b2b_paddr_a", paddr, 32'h1A10_5000);
    cyc();
    cyc(); prdata = 32'h3333_4444; #1;
    chk("b2b_gnt1", data_gnt, 1'b1);
    chk("b2b_rvalid0", data_rvalid, 1'b1);
    chk("b2b_rdata0", data_rdata, 32'h1111_2222);
    chk("b2b_nooverlap", psel, 1'b0);
    cyc(); data_req = 1'b0; #1;
    chk("b2b_paddr_b", paddr, 32'h1A10_6004);
    cyc();
    cyc(); #1;
    chk("b2b_rvalid1", data_rvalid, 1'b1);
    chk("b2b_rdata1", data_rdata, 32'h3333_4444);

    // Asynchronous reset during ACCESS
    cyc(); data_req = 1'b1; data_addr = 32'h1A10_7000; pready = 1'b0;
    cyc(); data_req = 1'b0;
    cyc(); #1;
    chk("rst_pre_pen", penable, 1'b1);
    #1 rst_n = 1'b0; pready = 1'b1;
    #1;
    chk("arst_psel", psel, 1'b0);
    chk("arst_penable", penable, 1'b0);
    cyc();
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("arst_no_rvalid", data_rvalid, 1'b0);
    end
    cyc(); data_req = 1'b1; data_addr = 32'h1A10_8000; prdata = 32'h55AA_55AA;
    cyc(); data_req = 1'b0;
    cyc();
    cyc(); #1;
    chk("post_rst_rvalid", data_rvalid, 1'b1);
    chk("post_rst_rdata", data_rdata, 32'h55AA_55AA);

    repeat (3) cyc();
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/obi_apb_bridge.md
# obi_apb_bridge

Converts the Ibex core's data-side request/grant/rvalid memory interface into APB3/APB4 master transfers. It sits directly upstream of the peripheral APB node, which decodes the single APB stream to the GPIO, UART and timer slaves. The bridge allows one outstanding transfer, generates SETUP and ACCESS phases, returns read data and errors to the core, and can abort transfers that stall past a programmable timeout.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32: address width on both sides.
- APB_DATA_WIDTH, 32: data width; byte-enable width is APB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 0: maximum ACCESS-phase length before abort. 0 disables the timeout.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_ni  in  1  asynchronous, active-low reset.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  request accepted this cycle.
- data_we_i  in  1  1 = write.
- data_be_i  in  DW/8  byte enables.
- data_addr_i  in  AW  byte address.
- data_wdata_i  in  DW  write data.
- data_rvalid_o  out  1  response valid, one cycle pulse.
- data_rdata_o  out  DW  read data, valid with rvalid.
- data_err_o  out  1  error response, valid with rvalid.
- apb_paddr_o  out  AW  APB address.
- apb_pwdata_o  out  DW  APB write data.
- apb_pwrite_o  out  1  APB write.
- apb_pstrb_o  out  DW/8  APB4 strobes.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_pready_i  in  1  slave ready.
- apb_prdata_i  in  DW  slave read data.
- apb_pslverr_i  in  1  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: data_gnt_o = data_req_i (combinational). On grant, register addr, wdata, we, and be (write) or all-ones (read) into the APB output registers, then go to SETUP. data_gnt_o is 0 in every other state.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS: psel=1, penable=1, with the timeout counter incrementing.
  - On pready=1: capture prdata (reads only; writes return 0) and pslverr. Go to IDLE and pulse rvalid in the next cycle.
  - With TIMEOUT_CYCLES>0, if the counter reaches TIMEOUT_CYCLES-1 with pready=0: end the transfer, go to IDLE, and pulse rvalid with err=1 and rdata=0. A late pready is ignored because psel is low by then.
- paddr, pwdata, pwrite and pstrb stay stable from SETUP through the last ACCESS cycle. They hold their last value while idle.
- data_err_o = captured pslverr OR timeout.
- The counter is AW-independent and sized clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It clears on entry to SETUP.
- At most one outstanding transfer. Back-to-back: a new request can be granted in the same cycle rvalid is high for the previous one.

## Timing
- Reset values: state IDLE; gnt, rvalid, err, psel, penable, pwrite = 0; paddr, pwdata, rdata = 0; pstrb = 0.
- The reset is asynchronous. Asserting it mid-transfer drops psel/penable immediately, and no rvalid is generated for the aborted transfer.
- Zero-wait-state latency: gnt in cycle 0, SETUP in cycle 1, ACCESS with pready in cycle 2, rvalid in cycle 3. Each pready wait state adds 1 cycle.
- Minimum request-to-request spacing is 3 cycles.
- rvalid is a registered single-cycle pulse. rdata and err are valid only while rvalid is high; they hold their values otherwise.
- data_req_i/address changes while the bridge is not in IDLE are ignored.

## Test plan
- Read, zero wait: addr 0x1A10_1000, pready high in the first ACCESS cycle, prdata 0xDEADBEEF -> gnt@0, psel@1, penable@2, rvalid@3 with rdata 0xDEADBEEF, err 0.
- Write with 3 wait states: be 4'b0011, wdata 0x1234_5678 -> pstrb 0011, pwrite 1, pwdata stable for 4 ACCESS cycles, rvalid 1 cycle after pready, rdata 0.
- Slave error: read with pslverr=1 at pready -> rvalid with err 1.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 -> psel drops after 8 ACCESS cycles, then rvalid with err 1 and rdata 0. A pready asserted later produces no second rvalid.
- Back-to-back: data_req_i held high for 2 reads -> second gnt coincides with the first rvalid, and there is no overlap of psel phases.
- Reset mid-ACCESS: assert rst_ni low while penable=1 -> psel/penable go to 0 asynchronously, no rvalid. A subsequent read completes normally.
